// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared types and constants for the E-stage control pipeline
package ctrl_pipe_pkg;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Q = 0;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_32   = 2'b01;
  localparam logic [1:0] RW_64   = 2'b11;

  // ALU control is kept outside the struct because its width is a module parameter
  typedef struct packed {
    logic [1:0] reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       pc_src;
    logic       no_write;
    logic       multi_cyc;
    logic       alu_src;
    logic [1:0] flag_write;
    logic [3:0] cond;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_ZERO = '0;

  typedef struct packed {
    logic [1:0] reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_src;
  } post_bundle_t;

  localparam post_bundle_t POST_ZERO = '0;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - condition field evaluation against {N,Z,C,V}
module cond_eval
  import ctrl_pipe_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  always_comb begin
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_mc.sv
// rtl/ctrl_pipe_mc.sv - carries decoded controls D->E->post stages, with flags and multi-cycle interlock
module ctrl_pipe_mc
  import ctrl_pipe_pkg::*;
#(
  parameter int ALUCONTROL_WIDTH = 6,
  parameter int ALU_FLAGS_WIDTH  = 5,
  parameter int POST_STAGES      = 2,
  parameter int MC_LATENCY       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  RegWriteD,
  input  logic                        MemWriteD,
  input  logic                        MemtoRegD,
  input  logic                        BranchD,
  input  logic                        PCSrcD,
  input  logic                        NoWriteD,
  input  logic                        MultiCycD,
  input  logic                        ALUSrcD,
  input  logic [1:0]                  FlagWriteD,
  input  logic [ALUCONTROL_WIDTH-1:0] ALUControlD,
  input  logic [3:0]                  CondD,
  input  logic [ALU_FLAGS_WIDTH-1:0]  ALUFlagsE,
  input  logic                        FlushE,
  output logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
  output logic                        ALUSrcE,
  output logic                        MemtoRegE,
  output logic                        BranchTakenE,
  output logic                        StallReqE,
  output logic [ALU_FLAGS_WIDTH-1:0]  FlagsE,
  output logic [1:0]                  RegWriteM,
  output logic                        MemWriteM,
  output logic [1:0]                  RegWriteW,
  output logic                        MemtoRegW,
  output logic                        PCSrcW,
  output logic                        PCWrPendingF
);

  localparam int CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;

  ctrl_bundle_t                bundle_d;
  ctrl_bundle_t                bundle_e;
  logic [ALUCONTROL_WIDTH-1:0] alu_ctrl_e;
  logic [ALU_FLAGS_WIDTH-1:0]  flags_q;
  mc_state_t                   state;
  logic [CNT_W-1:0]            cnt;
  post_bundle_t                post_q [1:POST_STAGES];
  post_bundle_t                post_in;
  logic                        cond_ex;
  logic                        mc_start;
  logic                        mc_drop;
  logic                        stall;
  logic                        complete;
  logic                        pend_mid;

  cond_eval u_cond_eval (
    .cond    (bundle_e.cond),
    .flags   (flags_q[FLAG_N:FLAG_V]),
    .cond_ex (cond_ex)
  );

  always_comb begin
    bundle_d            = CTRL_ZERO;
    bundle_d.reg_write  = RegWriteD;
    bundle_d.mem_write  = MemWriteD;
    bundle_d.mem_to_reg = MemtoRegD;
    bundle_d.branch     = BranchD;
    bundle_d.pc_src     = PCSrcD;
    bundle_d.no_write   = NoWriteD;
    bundle_d.multi_cyc  = MultiCycD;
    bundle_d.alu_src    = ALUSrcD;
    bundle_d.flag_write = FlagWriteD;
    bundle_d.cond       = CondD;
  end

  // The first E cycle of a multi-cycle op must already stall, so the stall is
  // decoded from state plus the E bundle rather than registered.
  always_comb begin
    mc_start = (state == MC_IDLE) & bundle_e.multi_cyc & cond_ex & !FlushE;
    mc_drop  = ((state != MC_IDLE) & FlushE) |
               ((state == MC_IDLE) & bundle_e.multi_cyc & FlushE);
    stall    = (state == MC_BUSY) | mc_start;
    complete = !stall & !mc_drop;

    post_in = POST_ZERO;
    if (complete) begin
      post_in.reg_write  = (bundle_e.no_write | !cond_ex) ? RW_NONE : bundle_e.reg_write;
      post_in.mem_write  = bundle_e.mem_write & cond_ex;
      post_in.mem_to_reg = bundle_e.mem_to_reg;
      post_in.pc_src     = bundle_e.pc_src & cond_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bundle_e   <= CTRL_ZERO;
      alu_ctrl_e <= '0;
      flags_q    <= '0;
      state      <= MC_IDLE;
      cnt        <= '0;
    end else begin
      if (FlushE) begin
        bundle_e   <= CTRL_ZERO;
        alu_ctrl_e <= '0;
      end else if (!stall) begin
        bundle_e   <= bundle_d;
        alu_ctrl_e <= ALUControlD;
      end

      if (complete & cond_ex) begin
        if (bundle_e.flag_write[1]) flags_q[FLAG_N:FLAG_Z] <= ALUFlagsE[FLAG_N:FLAG_Z];
        if (bundle_e.flag_write[0]) flags_q[FLAG_C:FLAG_Q] <= ALUFlagsE[FLAG_C:FLAG_Q];
      end

      case (state)
        MC_IDLE: begin
          if (mc_start) begin
            if (MC_LATENCY > 2) begin
              state <= MC_BUSY;
              cnt   <= CNT_W'(MC_LATENCY - 2);
            end else begin
              state <= MC_DONE;
            end
          end
        end
        MC_BUSY: begin
          if (FlushE) begin
            state <= MC_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(1)) begin
            state <= MC_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        MC_DONE: state <= MC_IDLE;
        default: begin
          state <= MC_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Post-E stages are never stalled; bubbles come from post_in during an occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 1; k <= POST_STAGES; k++) post_q[k] <= POST_ZERO;
    end else begin
      post_q[1] <= post_in;
      for (int k = 2; k <= POST_STAGES; k++) post_q[k] <= post_q[k-1];
    end
  end

  always_comb begin
    pend_mid = 1'b0;
    for (int k = 1; k < POST_STAGES; k++) pend_mid = pend_mid | post_q[k].pc_src;
  end

  assign ALUControlE  = alu_ctrl_e;
  assign ALUSrcE      = bundle_e.alu_src;
  assign MemtoRegE    = bundle_e.mem_to_reg;
  assign BranchTakenE = bundle_e.branch & cond_ex;
  assign StallReqE    = stall;
  assign FlagsE       = flags_q;
  assign RegWriteM    = post_q[1].reg_write;
  assign MemWriteM    = post_q[1].mem_write;
  assign RegWriteW    = post_q[POST_STAGES].reg_write;
  assign MemtoRegW    = post_q[POST_STAGES].mem_to_reg;
  assign PCSrcW       = post_q[POST_STAGES].pc_src;
  assign PCWrPendingF = PCSrcD | bundle_e.pc_src | pend_mid;

endmodule

// File: tb/tb_ctrl_pipe_mc.sv
// tb/tb_ctrl_pipe_mc.sv - self-checking bench for ctrl_pipe_mc
module tb_ctrl_pipe_mc;

  localparam int ACW = 6;
  localparam int AFW = 5;
  localparam int PS  = 3;
  localparam int MCL = 8;
  localparam logic [3:0] AL = 4'b1110;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     RegWriteD;
  logic           MemWriteD, MemtoRegD, BranchD, PCSrcD, NoWriteD, MultiCycD, ALUSrcD;
  logic [1:0]     FlagWriteD;
  logic [ACW-1:0] ALUControlD;
  logic [3:0]     CondD;
  logic [AFW-1:0] ALUFlagsE;
  logic           FlushE;
  logic [ACW-1:0] ALUControlE;
  logic           ALUSrcE, MemtoRegE, BranchTakenE, StallReqE;
  logic [AFW-1:0] FlagsE;
  logic [1:0]     RegWriteM;
  logic           MemWriteM;
  logic [1:0]     RegWriteW;
  logic           MemtoRegW, PCSrcW, PCWrPendingF;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_pipe_mc #(
    .ALUCONTROL_WIDTH (ACW),
    .ALU_FLAGS_WIDTH  (AFW),
    .POST_STAGES      (PS),
    .MC_LATENCY       (MCL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RegWriteD    (RegWriteD),
    .MemWriteD    (MemWriteD),
    .MemtoRegD    (MemtoRegD),
    .BranchD      (BranchD),
    .PCSrcD       (PCSrcD),
    .NoWriteD     (NoWriteD),
    .MultiCycD    (MultiCycD),
    .ALUSrcD      (ALUSrcD),
    .FlagWriteD   (FlagWriteD),
    .ALUControlD  (ALUControlD),
    .CondD        (CondD),
    .ALUFlagsE    (ALUFlagsE),
    .FlushE       (FlushE),
    .ALUControlE  (ALUControlE),
    .ALUSrcE      (ALUSrcE),
    .MemtoRegE    (MemtoRegE),
    .BranchTakenE (BranchTakenE),
    .StallReqE    (StallReqE),
    .FlagsE       (FlagsE),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegW    (MemtoRegW),
    .PCSrcW       (PCSrcW),
    .PCWrPendingF (PCWrPendingF)
  );

  wire [22:0] outs = {StallReqE, BranchTakenE, FlagsE, ALUControlE, ALUSrcE, MemtoRegE,
                      RegWriteM, MemWriteM, RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF};

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    RegWriteD = 2'b00; MemWriteD = 0; MemtoRegD = 0; BranchD = 0; PCSrcD = 0;
    NoWriteD = 0; MultiCycD = 0; ALUSrcD = 0; FlagWriteD = 2'b00;
    ALUControlD = '0; CondD = 4'b0000; ALUFlagsE = '0; FlushE = 0;
  endtask

  task automatic apply_reset();
    clear_d();
    reset = 1'b0;
    go();
    go();
    reset = 1'b1;
  endtask

  // Issues a flag-writing AL instruction; returns when the new flags are architectural.
  task automatic set_flags(input logic [4:0] f);
    clear_d();
    FlagWriteD = 2'b11; CondD = AL;
    go();
    clear_d();
    ALUFlagsE = f;
    go();
    clear_d();
  endtask

  function automatic logic cond_ok(input logic [3:0] cd, input logic [4:0] f);
    logic n, z, c, v;
    n = f[4]; z = f[3]; c = f[2]; v = f[1];
    case (cd)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (outs !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", outs, 23'd0);
    end
    go();
  endtask

  task automatic test_cond_write();
    set_flags(5'b01000);
    RegWriteD = 2'b01; CondD = 4'b0001;
    @(negedge clk);
    checks++;
    if (FlagsE !== 5'b01000) begin
      failures++;
      $display("FAIL cond_flags_setup: got %b expected %b", FlagsE, 5'b01000);
    end
    go();
    clear_d();
    go();
    @(negedge clk);
    checks++;
    if (RegWriteM !== 2'b00) begin
      failures++;
      $display("FAIL cond_ne_gated: got %b expected %b", RegWriteM, 2'b00);
    end
    go();
    RegWriteD = 2'b01; CondD = 4'b0000;
    go();
    clear_d();
    go();
    @(negedge clk);
    checks++;
    if (RegWriteM !== 2'b01) begin
      failures++;
      $display("FAIL cond_eq_m: got %b expected %b", RegWriteM, 2'b01);
    end
    go();
    @(negedge clk);
    checks++;
    if (RegWriteW !== 2'b00) begin
      failures++;
      $display("FAIL cond_eq_w_early: got %b expected %b", RegWriteW, 2'b00);
    end
    go();
    @(negedge clk);
    checks++;
    if (RegWriteW !== 2'b01 || RegWriteM !== 2'b00) begin
      failures++;
      $display("FAIL cond_eq_w: got W=%b M=%b expected W=01 M=00", RegWriteW, RegWriteM);
    end
    go();
  endtask

  task automatic test_partial_flags();
    set_flags(5'b00000);
    @(negedge clk);
    checks++;
    if (FlagsE !== 5'b00000) begin
      failures++;
      $display("FAIL partial_flags_clear: got %b expected %b", FlagsE, 5'b00000);
    end
    go();
    FlagWriteD = 2'b10; CondD = AL;
    go();
    clear_d();
    ALUFlagsE = 5'b11111;
    go();
    clear_d();
    @(negedge clk);
    checks++;
    if (FlagsE !== 5'b11000) begin
      failures++;
      $display("FAIL partial_flags: got %b expected %b", FlagsE, 5'b11000);
    end
    go();
  endtask

  task automatic test_multicycle();
    int highs;
    logic       exp_stall;
    logic [1:0] exp_rw;
    highs = 0;
    clear_d();
    MultiCycD = 1; RegWriteD = 2'b11; CondD = AL; ALUControlD = 6'h2a;
    go();
    clear_d();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_stall = (i < MCL - 1);
      exp_rw    = (i == MCL) ? 2'b11 : 2'b00;
      checks++;
      if (StallReqE !== exp_stall || RegWriteM !== exp_rw) begin
        failures++;
        $display("FAIL mc_cycle%0d: got stall=%b rwm=%b expected stall=%b rwm=%b",
                 i, StallReqE, RegWriteM, exp_stall, exp_rw);
      end
      if (StallReqE === 1'b1) highs++;
      go();
    end
    checks++;
    if (highs != MCL - 1) begin
      failures++;
      $display("FAIL mc_stall_count: got %0d expected %0d", highs, MCL - 1);
    end
  endtask

  task automatic test_flush_busy();
    set_flags(5'b11000);
    MultiCycD = 1; RegWriteD = 2'b11; FlagWriteD = 2'b11; CondD = AL; ALUControlD = 6'h2a;
    go();
    clear_d();
    ALUFlagsE = 5'b00111;
    for (int i = 0; i < 14; i++) begin
      FlushE = (i == 3);
      @(negedge clk);
      if (i == 2) begin
        checks++;
        if (ALUControlE !== 6'h2a || StallReqE !== 1'b1) begin
          failures++;
          $display("FAIL flush_hold: got aluctl=%h stall=%b expected aluctl=2a stall=1",
                   ALUControlE, StallReqE);
        end
      end
      if (i == 4) begin
        checks++;
        if (StallReqE !== 1'b0 || ALUControlE !== 6'h00) begin
          failures++;
          $display("FAIL flush_abort: got stall=%b aluctl=%h expected stall=0 aluctl=00",
                   StallReqE, ALUControlE);
        end
      end
      checks++;
      if (RegWriteM === 2'b11 || FlagsE !== 5'b11000) begin
        failures++;
        $display("FAIL flush_no_commit%0d: got rwm=%b flags=%b expected rwm!=11 flags=11000",
                 i, RegWriteM, FlagsE);
      end
      go();
    end
    clear_d();
  endtask

  task automatic test_reset_mid_op();
    set_flags(5'b11111);
    MultiCycD = 1; RegWriteD = 2'b11; CondD = AL;
    go();
    clear_d();
    go();
    go();
    go();
    reset = 1'b0;
    go();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (StallReqE !== 1'b0 || FlagsE !== 5'b00000 || RegWriteM !== 2'b00 ||
          MemWriteM !== 1'b0 || RegWriteW !== 2'b00 || MemtoRegW !== 1'b0 || PCSrcW !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_op%0d: got stall=%b flags=%b rwm=%b mwm=%b rww=%b m2rw=%b pcw=%b expected all zero",
                 i, StallReqE, FlagsE, RegWriteM, MemWriteM, RegWriteW, MemtoRegW, PCSrcW);
      end
      go();
    end
  endtask

  task automatic test_pc_pending();
    clear_d();
    for (int i = 0; i < 5; i++) go();
    PCSrcD = 1; CondD = AL;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (PCWrPendingF !== (i < 4) || PCSrcW !== (i == 4)) begin
        failures++;
        $display("FAIL pc_pending%0d: got pend=%b pcw=%b expected pend=%b pcw=%b",
                 i, PCWrPendingF, PCSrcW, (i < 4), (i == 4));
      end
      go();
      if (i == 0) clear_d();
    end
  endtask

  typedef struct packed {
    logic [1:0]     rw;
    logic           mw, m2r, br, pcs, nw, mc, as;
    logic [1:0]     fw;
    logic [3:0]     cond;
    logic [ACW-1:0] alu;
  } tb_ctl_t;

  task automatic test_random();
    tb_ctl_t    me;
    logic [4:0] mflags;
    int         occ;
    logic [4:0] mpipe [1:PS];
    logic       c, starting, exp_stall, complete, pend;
    logic [4:0] newent;
    logic [22:0] exp;
    apply_reset();
    me = '0; mflags = '0; occ = 0;
    for (int k = 1; k <= PS; k++) mpipe[k] = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      RegWriteD   = ($urandom_range(0, 2) == 2) ? 2'b11 : 2'($urandom_range(0, 1));
      MemWriteD   = 1'($urandom);
      MemtoRegD   = 1'($urandom);
      BranchD     = 1'($urandom);
      PCSrcD      = ($urandom_range(0, 3) == 0);
      NoWriteD    = ($urandom_range(0, 3) == 0);
      MultiCycD   = ($urandom_range(0, 5) == 0);
      ALUSrcD     = 1'($urandom);
      FlagWriteD  = 2'($urandom);
      ALUControlD = ACW'($urandom);
      CondD       = 4'($urandom);
      ALUFlagsE   = AFW'($urandom);
      FlushE      = ($urandom_range(0, 11) == 0);
      @(negedge clk);
      c         = cond_ok(me.cond, mflags);
      starting  = (occ == 0) && me.mc && c && !FlushE;
      exp_stall = starting || (occ >= 1 && occ <= MCL - 2);
      complete  = (occ == 0) ? (!starting && !(me.mc && FlushE)) : (occ == MCL - 1 && !FlushE);
      pend      = PCSrcD | me.pcs;
      for (int k = 1; k < PS; k++) pend = pend | mpipe[k][0];
      exp = {exp_stall, me.br & c, mflags, me.alu, me.as, me.m2r,
             mpipe[1][4:3], mpipe[1][2], mpipe[PS][4:3], mpipe[PS][1], mpipe[PS][0], pend};
      checks++;
      if (outs !== exp) begin
        failures++;
        $display("FAIL random_cycle%0d: got %h expected %h", cyc, outs, exp);
      end
      newent = complete ? {(me.nw || !c) ? 2'b00 : me.rw, me.mw & c, me.m2r, me.pcs & c} : 5'b0;
      for (int k = PS; k >= 2; k--) mpipe[k] = mpipe[k-1];
      mpipe[1] = newent;
      if (complete && c) begin
        if (me.fw[1]) mflags[4:3] = ALUFlagsE[4:3];
        if (me.fw[0]) mflags[2:0] = ALUFlagsE[2:0];
      end
      if (FlushE) occ = 0;
      else if (occ == 0) occ = starting ? 1 : 0;
      else if (occ == MCL - 1) occ = 0;
      else occ = occ + 1;
      if (FlushE) me = '0;
      else if (!exp_stall)
        me = '{rw: RegWriteD, mw: MemWriteD, m2r: MemtoRegD, br: BranchD, pcs: PCSrcD,
               nw: NoWriteD, mc: MultiCycD, as: ALUSrcD, fw: FlagWriteD, cond: CondD,
               alu: ALUControlD};
      go();
    end
    clear_d();
  endtask

  initial begin
    reset = 1'b0;
    clear_d();
    test_reset();
    test_cond_write();
    test_partial_flags();
    test_multicycle();
    test_flush_busy();
    test_reset_mid_op();
    test_pc_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_mc.md
Name: ctrl_pipe_mc

Overview:
- Parametrised successor to the pipeline controller's control-propagation half; decode stays outside.
- Takes a pre-decoded control bundle at D and carries it through E and a configurable number of post-E stages, ending at W.
- Evaluates conditions and the flags register in E.
- Adds E-stage stall/hold and a multi-cycle-op interlock (UDIV/SDIV) that requests an upstream stall while the op is busy.

Parameters:
- ALUCONTROL_WIDTH, 6, width of ALU control code
- ALU_FLAGS_WIDTH, 5, flag vector {N,Z,C,V,Q}, MSB first
- POST_STAGES, 2, stages after E (min 2); stage 1 = M, stage POST_STAGES = W
- MC_LATENCY, 8, E-occupancy cycles of a multi-cycle op (min 2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- RegWriteD  in  2  00 none / 01 32-bit / 11 64-bit
- MemWriteD, MemtoRegD, BranchD, PCSrcD, NoWriteD, MultiCycD, ALUSrcD  in  1 each  decoded controls
- FlagWriteD  in  2  [1]: N,Z; [0]: C,V,Q
- ALUControlD  in  ALUCONTROL_WIDTH  ALU op
- CondD  in  4  condition field
- ALUFlagsE  in  ALU_FLAGS_WIDTH  ALU result flags
- FlushE  in  1  bubble into E
- ALUControlE  out  ALUCONTROL_WIDTH  E-stage op
- ALUSrcE, MemtoRegE  out  1 each  E-stage controls
- BranchTakenE  out  1  branch resolved taken
- StallReqE  out  1  hold F/D/E this cycle
- FlagsE  out  ALU_FLAGS_WIDTH  architectural flags
- RegWriteM  out  2  gated write at M
- MemWriteM  out  1  gated write at M
- RegWriteW  out  2  gated write at W
- MemtoRegW, PCSrcW  out  1 each  W-stage controls
- PCWrPendingF  out  1  PC write in flight

Behaviour:
- Reset (reset==0 at a clk edge): all stage registers, FlagsE, FSM and counter cleared; every output 0.
- Cond (flags N,Z,C,V): 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 and 1111 always. CondExE is computed from the registered FlagsE.
- E register:
  - FlushE=1: loads the all-zero bundle (clear has priority over hold).
  - StallReqE=1: holds.
  - Otherwise: loads the D bundle.
- Gating in E:
  - BranchTakenE = BranchE & CondExE.
  - RegWrite gated = 00 if NoWriteE or !CondExE.
  - MemWrite and PCSrc are ANDed with CondExE.
- Flags: on completion of the E occupancy, FlagsE[4:3] <= ALUFlagsE[4:3] if FlagWriteE[1]&CondExE; FlagsE[2:0] <= ALUFlagsE[2:0] if FlagWriteE[0]&CondExE. Completion = the single cycle for a single-cycle op, or the DONE cycle for a multi-cycle op. Flags update exactly once per instruction.
- FSM IDLE / BUSY / DONE, counter width clog2(MC_LATENCY):
  - IDLE: if MultiCycE & CondExE & !FlushE, go to BUSY with cnt=MC_LATENCY-2 and StallReqE=1. A failed cond (or FlushE) skips BUSY and the op passes in 1 cycle as a NOP.
  - BUSY: StallReqE=1. The zero bundle is injected into M each cycle. cnt decrements; at 0 go to DONE.
  - DONE: StallReqE=0. The E bundle advances to M with gating and the flag update, then go to IDLE.
  - FlushE in BUSY or DONE: abort to IDLE, no flag update, zero bundle to M.
  - Total E occupancy = MC_LATENCY cycles.
- Post-E stages: plain shift registers of {RegWrite, MemWrite, MemtoReg, PCSrc}, never stalled. RegWriteM and MemWriteM come from stage 1; W outputs come from stage POST_STAGES.
- PCWrPendingF = PCSrcD | PCSrcE (ungated) | PCSrc of stages 1..POST_STAGES-1.
- ALUSrcE and ALUControlE follow the E register, including hold and clear.

Decomposition:
- Package ctrl_pipe_pkg: flag bit indices (N=4, Z=3, C=2, V=1, Q=0), condition-code constants, RegWrite encodings, control-bundle struct and its zero value.
- Sub-module cond_eval: combinational Cond, Flags -> CondEx.
- FSM and stage shift register stay inline.

Test Plan:
- Reset: assert reset=0 mid multi-cycle op -> next cycle StallReqE=0, FlagsE=00000, all M/W outputs 0.
- Conditional write: FlagsE Z=1, CondD=0001, RegWriteD=01 -> RegWriteM=00 one cycle after E. Same with CondD=0000 -> RegWriteM=01, RegWriteW=01 at cycle POST_STAGES after E.
- Partial flag write: FlagWriteD=10, ALUFlagsE=11111 with FlagsE=00000 -> FlagsE=11000 next cycle.
- Multi-cycle op (MC_LATENCY=8): MultiCycD=1, RegWriteD=11, cond AL -> StallReqE high exactly 7 cycles, six zero bundles then a bubble into M, RegWriteM=11 in the cycle after DONE.
- Flush during BUSY at cycle 3 -> FSM IDLE next cycle, StallReqE=0, no RegWriteM=11 ever, FlagsE unchanged.
- PC pending: PCSrcD=1 pulse with cond AL, POST_STAGES=3 -> PCWrPendingF high 4 consecutive cycles (D, E, M1, M2), then PCSrcW=1.
